// File: rtl/mem_port_arbiter_if.sv
// Signal bundle around mem_port_arbiter: I/D cache requests, the shared memory
// port and the refill/done/busy returns to the caches.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 4
);
    localparam int unsigned IDX_W = $clog2(LINE_WORDS);

    // Cache requests
    logic              i_ic_req;
    logic [ADDR_W-1:0] i_ic_addr;
    logic              i_dc_req;
    logic              i_dc_we;
    logic [ADDR_W-1:0] i_dc_addr;
    logic [DATA_W-1:0] i_dc_wdata;

    // Memory port
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              i_mem_ack;
    logic [DATA_W-1:0] i_mem_rdata;

    // Refill return and status
    logic              o_ic_fill_valid;
    logic              o_dc_fill_valid;
    logic [IDX_W-1:0]  o_fill_idx;
    logic [DATA_W-1:0] o_fill_data;
    logic              o_ic_done;
    logic              o_dc_done;
    logic              o_ic_busy;
    logic              o_dc_busy;

    // Arbiter side.
    modport slave (
        input  i_ic_req, i_ic_addr, i_dc_req, i_dc_we, i_dc_addr, i_dc_wdata,
        input  i_mem_ack, i_mem_rdata,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        output o_ic_fill_valid, o_dc_fill_valid, o_fill_idx, o_fill_data,
        output o_ic_done, o_dc_done, o_ic_busy, o_dc_busy
    );

    // Caches and memory, driving requests and acks.
    modport master (
        output i_ic_req, i_ic_addr, i_dc_req, i_dc_we, i_dc_addr, i_dc_wdata,
        output i_mem_ack, i_mem_rdata,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        input  o_ic_fill_valid, o_dc_fill_valid, o_fill_idx, o_fill_data,
        input  o_ic_done, o_dc_done, o_ic_busy, o_dc_busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between I-cache line refills and D-cache
// refills / single-word write-throughs. D wins by default; after MAX_D_STREAK
// consecutive D grants taken while I was waiting, I is granted once.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned LINE_WORDS   = 4,
    parameter int unsigned MAX_D_STREAK = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned IDX_W      = $clog2(LINE_WORDS);
    localparam int unsigned WORD_BYTES = DATA_W / 8;
    localparam int unsigned LINE_BYTES = LINE_WORDS * WORD_BYTES;
    localparam int unsigned STREAK_W   = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;

    localparam logic [ADDR_W-1:0]   LineMask  = ~(ADDR_W'(LINE_BYTES - 1));
    localparam logic [ADDR_W-1:0]   WordMask  = ~(ADDR_W'(WORD_BYTES - 1));
    localparam logic [ADDR_W-1:0]   WordStep  = ADDR_W'(WORD_BYTES);
    localparam logic [IDX_W-1:0]    LastIdx   = IDX_W'(LINE_WORDS - 1);
    localparam logic [IDX_W-1:0]    CntOne    = IDX_W'(1);
    localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(MAX_D_STREAK);
    localparam logic [STREAK_W-1:0] StreakOne = STREAK_W'(1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBurst  = 2'd1,
        StFinish = 2'd2
    } state_e;

    typedef enum logic {
        OwnI = 1'b0,
        OwnD = 1'b1
    } owner_e;

    state_e              state_q;
    owner_e              owner_q;
    logic                wr_q;
    logic [IDX_W-1:0]    cnt_q;
    logic [STREAK_W-1:0] streak_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic                ic_done_q;
    logic                dc_done_q;

    logic grant_i;
    logic fill_fire;

    // Arbitration outcome, only acted on in StIdle.
    always_comb begin
        grant_i = 1'b0;
        if (bus.i_ic_req && (!bus.i_dc_req || (streak_q == StreakMax))) begin
            grant_i = 1'b1;
        end
    end

    // Transaction FSM: grant, word-by-word burst, one-cycle done, back to idle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= StIdle;
            owner_q   <= OwnI;
            wr_q      <= 1'b0;
            cnt_q     <= '0;
            streak_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
        end else begin
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.i_ic_req || bus.i_dc_req) begin
                        state_q   <= StBurst;
                        cnt_q     <= '0;
                        mem_req_q <= 1'b1;
                        if (grant_i) begin
                            owner_q  <= OwnI;
                            wr_q     <= 1'b0;
                            mem_we_q <= 1'b0;
                            addr_q   <= bus.i_ic_addr & LineMask;
                            wdata_q  <= '0;
                            streak_q <= '0;
                        end else begin
                            owner_q  <= OwnD;
                            wr_q     <= bus.i_dc_we;
                            mem_we_q <= bus.i_dc_we;
                            addr_q   <= bus.i_dc_addr & (bus.i_dc_we ? WordMask : LineMask);
                            wdata_q  <= bus.i_dc_we ? bus.i_dc_wdata : '0;
                            // Streak only grows while I is kept waiting; at the cap I wins
                            // instead, so the increment cannot overflow.
                            streak_q <= bus.i_ic_req ? (streak_q + StreakOne) : '0;
                        end
                    end
                end
                StBurst: begin
                    if (bus.i_mem_ack) begin
                        if (wr_q || (cnt_q == LastIdx)) begin
                            state_q   <= StFinish;
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            ic_done_q <= (owner_q == OwnI);
                            dc_done_q <= (owner_q == OwnD);
                        end else begin
                            cnt_q  <= cnt_q + CntOne;
                            addr_q <= addr_q + WordStep;
                        end
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // A read word is handed to its owner in the same cycle memory acks it.
    assign fill_fire = (state_q == StBurst) && bus.i_mem_ack && !wr_q;

    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;

    assign bus.o_ic_fill_valid = fill_fire && (owner_q == OwnI);
    assign bus.o_dc_fill_valid = fill_fire && (owner_q == OwnD);
    assign bus.o_fill_idx      = fill_fire ? cnt_q : '0;
    assign bus.o_fill_data     = fill_fire ? bus.i_mem_rdata : '0;

    assign bus.o_ic_done = ic_done_q;
    assign bus.o_dc_done = dc_done_q;

    // Busy feeds the hazard unit's stall inputs: pending or in service.
    assign bus.o_ic_busy = bus.i_ic_req || ((owner_q == OwnI) && (state_q != StIdle));
    assign bus.o_dc_busy = bus.i_dc_req || ((owner_q == OwnD) && (state_q != StIdle));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned LINE_WORDS   = 4;
    localparam int unsigned MAX_D_STREAK = 2;
    localparam logic [31:0] LINE_MASK    = ~32'(LINE_WORDS * DATA_W / 8 - 1);
    localparam logic [31:0] WORD_MASK    = ~32'(DATA_W / 8 - 1);

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    mem_port_arbiter_if #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS)
    ) bus ();

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .LINE_WORDS   (LINE_WORDS),
        .MAX_D_STREAK (MAX_D_STREAK)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    logic [103:0] all_out;
    assign all_out = {bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata,
                      bus.o_ic_fill_valid, bus.o_dc_fill_valid, bus.o_fill_idx,
                      bus.o_fill_data, bus.o_ic_done, bus.o_dc_done};

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_ic_req    = 1'b0;
        bus.i_ic_addr   = '0;
        bus.i_dc_req    = 1'b0;
        bus.i_dc_we     = 1'b0;
        bus.i_dc_addr   = '0;
        bus.i_dc_wdata  = '0;
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = '0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        Rst = 1'b0;
        bus.i_ic_req = 1'b1;  bus.i_ic_addr = 32'h104;
        bus.i_dc_req = 1'b1;  bus.i_dc_addr = 32'h2000;
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h1234_5678;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out);
        else n_pass++;
        @(posedge Clk); #1;
        Rst = 1'b1; bus.i_dc_req = 1'b0; bus.i_mem_ack = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            exp_addr = 32'h100 + 32'(4 * k);
            exp_data = 32'hC0DE_0000 + 32'(k);
            bus.i_mem_ack = 1'b1; bus.i_mem_rdata = exp_data;
            @(negedge Clk);
            n_checks++;
            if ({bus.o_mem_req, bus.o_mem_addr} !== {1'b1, exp_addr})
                $display("FAIL reset_refill_addr[%0d]: got %b/%h want 1/%h", k, bus.o_mem_req,
                         bus.o_mem_addr, exp_addr);
            else n_pass++;
            n_checks++;
            if ({bus.o_ic_fill_valid, bus.o_dc_fill_valid, bus.o_fill_idx, bus.o_fill_data} !==
                {2'b10, 2'(k), exp_data})
                $display("FAIL reset_refill_fill[%0d]: got %b%b/%0d/%h want 10/%0d/%h", k,
                         bus.o_ic_fill_valid, bus.o_dc_fill_valid, bus.o_fill_idx,
                         bus.o_fill_data, k, exp_data);
            else n_pass++;
            step();
        end
        bus.i_mem_ack = 1'b0;
        @(negedge Clk);
        n_checks++;
        if ({bus.o_ic_done, bus.o_dc_done, bus.o_mem_req} !== 3'b100)
            $display("FAIL reset_refill_done: got %b%b%b want 100", bus.o_ic_done,
                     bus.o_dc_done, bus.o_mem_req);
        else n_pass++;
        step();
        bus.i_ic_req = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (bus.o_ic_done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", bus.o_ic_done);
        else n_pass++;
    endtask

    task automatic test_write_wait();
        bus.i_dc_req = 1'b1; bus.i_dc_we = 1'b1;
        bus.i_dc_addr = 32'h2008; bus.i_dc_wdata = 32'hDEAD_BEEF;
        step();
        for (int w = 0; w < 4; w++) begin
            bus.i_mem_ack = (w == 3); bus.i_mem_rdata = $urandom();
            @(negedge Clk);
            n_checks++;
            if ({bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata} !==
                {2'b11, 32'h2008, 32'hDEAD_BEEF})
                $display("FAIL write_bus[%0d]: got %b%b/%h/%h want 11/00002008/deadbeef", w,
                         bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata);
            else n_pass++;
            n_checks++;
            if ({bus.o_ic_fill_valid, bus.o_dc_fill_valid} !== 2'b00)
                $display("FAIL write_no_fill[%0d]: got %b%b want 00", w, bus.o_ic_fill_valid,
                         bus.o_dc_fill_valid);
            else n_pass++;
            step();
        end
        bus.i_mem_ack = 1'b0;
        @(negedge Clk);
        n_checks++;
        if ({bus.o_ic_done, bus.o_dc_done, bus.o_mem_req} !== 3'b010)
            $display("FAIL write_done: got %b%b%b want 010", bus.o_ic_done, bus.o_dc_done,
                     bus.o_mem_req);
        else n_pass++;
        step();
        bus.i_dc_req = 1'b0; bus.i_dc_we = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_addr;
        logic [1:0]  exp_fv;
        logic [31:0] base;
        bus.i_ic_req = 1'b1; bus.i_ic_addr = 32'h300C;
        bus.i_dc_req = 1'b1; bus.i_dc_we = 1'b0; bus.i_dc_addr = 32'h4014;
        for (int t = 0; t < 2; t++) begin
            base   = (t == 0) ? 32'h4010 : 32'h3000;
            exp_fv = (t == 0) ? 2'b01 : 2'b10;
            step();
            for (int k = 0; k < 4; k++) begin
                exp_addr = base + 32'(4 * k);
                bus.i_mem_ack = 1'b1; bus.i_mem_rdata = $urandom();
                @(negedge Clk);
                n_checks++;
                if ({bus.o_mem_addr, bus.o_ic_fill_valid, bus.o_dc_fill_valid, bus.o_fill_idx} !==
                    {exp_addr, exp_fv, 2'(k)})
                    $display("FAIL simul_word[%0d.%0d]: got %h/%b%b/%0d want %h/%b/%0d", t, k,
                             bus.o_mem_addr, bus.o_ic_fill_valid, bus.o_dc_fill_valid,
                             bus.o_fill_idx, exp_addr, exp_fv, k);
                else n_pass++;
                step();
            end
            bus.i_mem_ack = 1'b0;
            @(negedge Clk);
            n_checks++;
            if ({bus.o_ic_done, bus.o_dc_done} !== exp_fv)
                $display("FAIL simul_done[%0d]: got %b%b want %b", t, bus.o_ic_done,
                         bus.o_dc_done, exp_fv);
            else n_pass++;
            step();
            if (t == 0) begin
                bus.i_dc_req = 1'b0;
                @(negedge Clk);
                n_checks++;
                if ({bus.o_mem_req, bus.o_ic_busy} !== 2'b01)
                    $display("FAIL simul_gap: got req=%b ic_busy=%b want 0/1", bus.o_mem_req,
                             bus.o_ic_busy);
                else n_pass++;
            end
        end
        bus.i_ic_req = 1'b0;
    endtask

    task automatic test_starvation();
        bit          exp_is_i [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int          got = 0;
        int          cyc = 0;
        logic [31:0] exp_addr;
        bus.i_ic_req = 1'b1; bus.i_ic_addr = 32'h5000;
        bus.i_dc_req = 1'b1; bus.i_dc_we = 1'b0; bus.i_dc_addr = 32'h6000;
        bus.i_mem_ack = 1'b1;
        while (got < 6 && cyc < 100) begin
            @(negedge Clk);
            if ((bus.o_ic_fill_valid || bus.o_dc_fill_valid) && bus.o_fill_idx == 2'd0) begin
                exp_addr = exp_is_i[got] ? 32'h5000 : 32'h6000;
                n_checks++;
                if ({bus.o_ic_fill_valid, bus.o_mem_addr} !== {exp_is_i[got], exp_addr})
                    $display("FAIL grant_order[%0d]: got is_i=%b addr=%h want is_i=%b addr=%h",
                             got, bus.o_ic_fill_valid, bus.o_mem_addr, exp_is_i[got], exp_addr);
                else n_pass++;
                got++;
            end
            step();
            cyc++;
        end
        if (got < 6) begin
            n_checks++;
            $display("FAIL grant_order_timeout: got %0d grants want 6", got);
        end
        bus.i_ic_req = 1'b0; bus.i_dc_req = 1'b0;
        repeat (8) step();
        bus.i_mem_ack = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] exp_addr;
        bus.i_dc_req = 1'b1; bus.i_dc_we = 1'b0; bus.i_dc_addr = 32'h7000;
        step();
        for (int k = 0; k < 2; k++) begin
            bus.i_mem_ack = 1'b1; bus.i_mem_rdata = $urandom();
            step();
        end
        bus.i_mem_ack = 1'b0;
        Rst = 1'b0;
        #1;
        n_checks++;
        if (all_out !== '0) $display("FAIL midreset_outputs: got %h want 0", all_out);
        else n_pass++;
        bus.i_dc_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            n_checks++;
            if ({bus.o_dc_done, bus.o_mem_req} !== 2'b00)
                $display("FAIL midreset_no_done[%0d]: got %b%b want 00", c, bus.o_dc_done,
                         bus.o_mem_req);
            else n_pass++;
        end
        @(posedge Clk); #1;
        Rst = 1'b1; bus.i_ic_req = 1'b1; bus.i_ic_addr = 32'h8008;
        step();
        for (int k = 0; k < 4; k++) begin
            exp_addr = 32'h8000 + 32'(4 * k);
            bus.i_mem_ack = 1'b1; bus.i_mem_rdata = $urandom();
            @(negedge Clk);
            n_checks++;
            if ({bus.o_mem_addr, bus.o_ic_fill_valid, bus.o_fill_idx} !== {exp_addr, 1'b1, 2'(k)})
                $display("FAIL midreset_restart[%0d]: got %h/%b/%0d want %h/1/%0d", k,
                         bus.o_mem_addr, bus.o_ic_fill_valid, bus.o_fill_idx, exp_addr, k);
            else n_pass++;
            step();
        end
        bus.i_mem_ack = 1'b0;
        @(negedge Clk);
        n_checks++;
        if ({bus.o_ic_done, bus.o_dc_done} !== 2'b10)
            $display("FAIL midreset_done: got %b%b want 10", bus.o_ic_done, bus.o_dc_done);
        else n_pass++;
        step();
        bus.i_ic_req = 1'b0;
    endtask

    task automatic test_dropped_req();
        logic [31:0] exp_data;
        bus.i_ic_req = 1'b1; bus.i_ic_addr = 32'h900C;
        step();
        for (int k = 0; k < 4; k++) begin
            exp_data = $urandom();
            bus.i_mem_ack = 1'b1; bus.i_mem_rdata = exp_data;
            @(negedge Clk);
            n_checks++;
            if ({bus.o_mem_addr, bus.o_ic_fill_valid, bus.o_fill_idx, bus.o_fill_data,
                 bus.o_ic_busy} !== {32'h9000 + 32'(4 * k), 1'b1, 2'(k), exp_data, 1'b1})
                $display("FAIL dropped_word[%0d]: got %h/%b/%0d/%h busy=%b", k, bus.o_mem_addr,
                         bus.o_ic_fill_valid, bus.o_fill_idx, bus.o_fill_data, bus.o_ic_busy);
            else n_pass++;
            step();
            if (k == 0) bus.i_ic_req = 1'b0;
        end
        bus.i_mem_ack = 1'b0;
        @(negedge Clk);
        n_checks++;
        if ({bus.o_ic_done, bus.o_ic_busy} !== 2'b11)
            $display("FAIL dropped_done: got done=%b busy=%b want 1/1", bus.o_ic_done,
                     bus.o_ic_busy);
        else n_pass++;
        step();
        @(negedge Clk);
        n_checks++;
        if ({bus.o_ic_done, bus.o_ic_busy} !== 2'b00)
            $display("FAIL dropped_idle: got done=%b busy=%b want 0/0", bus.o_ic_done,
                     bus.o_ic_busy);
        else n_pass++;
        step();
    endtask

    // Reference: a queue of word addresses still owed by the granted transaction,
    // followed by one done cycle and one idle cycle before the next grant.
    task automatic test_random();
        logic [31:0] m_q[$];
        bit          m_done = 1'b0;
        bit          m_own_d = 1'b0;
        bit          m_we = 1'b0;
        logic [31:0] m_wdata = '0;
        int          m_idx = 0;
        int          m_streak = 0;
        bit          give_i, pending, fire, free;
        bit          ic_finished = 1'b0;
        bit          dc_finished = 1'b0;
        logic [1:0]  exp2;
        for (int c = 0; c < 1500; c++) begin
            @(posedge Clk);
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_q.size() != 0) begin
                if (bus.i_mem_ack) begin
                    void'(m_q.pop_front());
                    m_idx++;
                    if (m_q.size() == 0) m_done = 1'b1;
                end
            end else if (bus.i_ic_req || bus.i_dc_req) begin
                give_i = bus.i_ic_req && (!bus.i_dc_req || m_streak >= MAX_D_STREAK);
                m_idx  = 0;
                if (give_i) begin
                    m_own_d = 1'b0; m_we = 1'b0; m_streak = 0;
                    for (int w = 0; w < LINE_WORDS; w++)
                        m_q.push_back((bus.i_ic_addr & LINE_MASK) + 32'(4 * w));
                end else begin
                    m_own_d  = 1'b1;
                    m_streak = bus.i_ic_req ? m_streak + 1 : 0;
                    m_we     = bus.i_dc_we;
                    m_wdata  = bus.i_dc_wdata;
                    if (m_we) m_q.push_back(bus.i_dc_addr & WORD_MASK);
                    else for (int w = 0; w < LINE_WORDS; w++)
                        m_q.push_back((bus.i_dc_addr & LINE_MASK) + 32'(4 * w));
                end
            end
            #1;
            if (ic_finished) bus.i_ic_req = 1'b0;
            else if (!bus.i_ic_req && $urandom_range(0, 3) == 0) begin
                bus.i_ic_req = 1'b1; bus.i_ic_addr = $urandom();
            end else if ($urandom_range(0, 7) == 0) bus.i_ic_addr = $urandom();
            if (dc_finished) bus.i_dc_req = 1'b0;
            else if (!bus.i_dc_req && $urandom_range(0, 2) == 0) begin
                bus.i_dc_req = 1'b1; bus.i_dc_addr = $urandom();
                bus.i_dc_we = 1'($urandom_range(0, 1)); bus.i_dc_wdata = $urandom();
            end else if ($urandom_range(0, 7) == 0) bus.i_dc_addr = $urandom();
            bus.i_mem_ack   = ($urandom_range(0, 2) != 0);
            bus.i_mem_rdata = $urandom();
            @(negedge Clk);
            pending = (m_q.size() != 0);
            fire    = pending && !m_we && bus.i_mem_ack;
            free    = !pending && !m_done;
            n_checks++;
            if (bus.o_mem_req !== pending)
                $display("FAIL rnd_mem_req @%0d: got %b want %b", c, bus.o_mem_req, pending);
            else n_pass++;
            if (pending) begin
                n_checks++;
                if ({bus.o_mem_addr, bus.o_mem_we, (m_we ? bus.o_mem_wdata : 32'h0)} !==
                    {m_q[0], m_we, (m_we ? m_wdata : 32'h0)})
                    $display("FAIL rnd_mem_bus @%0d: got %h/%b/%h want %h/%b/%h", c,
                             bus.o_mem_addr, bus.o_mem_we, bus.o_mem_wdata, m_q[0], m_we, m_wdata);
                else n_pass++;
            end
            exp2 = {fire && !m_own_d, fire && m_own_d};
            n_checks++;
            if ({bus.o_ic_fill_valid, bus.o_dc_fill_valid} !== exp2)
                $display("FAIL rnd_fill_valid @%0d: got %b%b want %b", c, bus.o_ic_fill_valid,
                         bus.o_dc_fill_valid, exp2);
            else n_pass++;
            if (fire) begin
                n_checks++;
                if ({bus.o_fill_idx, bus.o_fill_data} !== {2'(m_idx), bus.i_mem_rdata})
                    $display("FAIL rnd_fill_word @%0d: got %0d/%h want %0d/%h", c,
                             bus.o_fill_idx, bus.o_fill_data, m_idx, bus.i_mem_rdata);
                else n_pass++;
            end
            exp2 = {m_done && !m_own_d, m_done && m_own_d};
            n_checks++;
            if ({bus.o_ic_done, bus.o_dc_done} !== exp2)
                $display("FAIL rnd_done @%0d: got %b%b want %b", c, bus.o_ic_done,
                         bus.o_dc_done, exp2);
            else n_pass++;
            exp2 = {bus.i_ic_req || (!free && !m_own_d), bus.i_dc_req || (!free && m_own_d)};
            n_checks++;
            if ({bus.o_ic_busy, bus.o_dc_busy} !== exp2)
                $display("FAIL rnd_busy @%0d: got %b%b want %b", c, bus.o_ic_busy,
                         bus.o_dc_busy, exp2);
            else n_pass++;
            ic_finished = m_done && !m_own_d;
            dc_finished = m_done && m_own_d;
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_write_wait();
        test_simultaneous();
        test_starvation();
        test_reset_mid_burst();
        test_dropped_req();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single main-memory port between instruction-cache refills (IF stage) and data-cache refills and write-throughs (MA stage). Each miss becomes a line-burst or single-word transaction on the memory port. Data is returned word by word to the owning cache, and completion is signalled with a one-cycle done pulse. The block sits beside the hazard unit. The `o_ic_busy` and `o_dc_busy` outputs drive the I-miss and D-miss stall inputs.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: memory word width.
- `LINE_WORDS`, 4: words per cache line. Power of two, ≥2.
- `MAX_D_STREAK`, 2: consecutive D grants allowed while I is pending.

Ports:
- `Clk` in 1: clock. All state changes on the rising edge.
- `Rst` in 1: asynchronous, active-low reset.
- `i_ic_req` in 1: I-cache line refill request.
- `i_ic_addr` in `ADDR_W`: I miss address.
- `i_dc_req` in 1: D-cache request.
- `i_dc_we` in 1: 1 = single-word write-through, 0 = line refill.
- `i_dc_addr` in `ADDR_W`: D address.
- `i_dc_wdata` in `DATA_W`: write data.
- `o_mem_req` out 1: memory transfer request.
- `o_mem_we` out 1: memory write.
- `o_mem_addr` out `ADDR_W`: word-aligned address.
- `o_mem_wdata` out `DATA_W`: write data.
- `i_mem_ack` in 1: memory completes the current word.
- `i_mem_rdata` in `DATA_W`: read data, valid with `i_mem_ack`.
- `o_ic_fill_valid`, `o_dc_fill_valid` out 1: refill word valid this cycle.
- `o_fill_idx` out log2(`LINE_WORDS`): word index within the line.
- `o_fill_data` out `DATA_W`: refill word.
- `o_ic_done`, `o_dc_done` out 1: one-cycle completion pulse.
- `o_ic_busy`, `o_dc_busy` out 1: the side has a request that is pending or in service.

## Operation
- States: `IDLE`, `BURST`, `FINISH`.
- Owner register: `owner` ∈ {I, D}. Write flag `wr`.
- Word counter: `cnt`, width log2(`LINE_WORDS`).
- Streak counter: `dstreak`, saturates at `MAX_D_STREAK`.

In `IDLE`, when any request is asserted:
- Arbitration:
  - D wins by default.
  - I wins if `i_ic_req` is set and `dstreak == MAX_D_STREAK`.
  - I wins if only I is requesting.
- On a D grant with I pending: `dstreak++`.
- On an I grant: `dstreak ← 0`.
- On a D grant with I not pending: `dstreak ← 0`.
- Latch the line base as `addr & ~(LINE_WORDS*DATA_W/8 - 1)`. For writes, latch the word-aligned address and `i_dc_wdata`.
- Set `cnt ← 0` and go to `BURST`.

In `BURST`:
- `o_mem_req` = 1 and `o_mem_addr` = base + `cnt`·(`DATA_W`/8).
- `o_mem_we` = `wr` and `o_mem_wdata` = latched data.
- On `i_mem_ack` for a read:
  - Assert the owner's `fill_valid` combinationally in the same cycle.
  - Drive `o_fill_data` = `i_mem_rdata` and `o_fill_idx` = `cnt`.
  - `cnt++`.
- After the ack with `cnt == LINE_WORDS-1`, or the write's single ack: go to `FINISH`.
- `o_mem_req` stays high between words (back-to-back bursts). The address advances in the cycle after each ack.

In `FINISH`:
- Pulse the owner's done for one cycle with `o_mem_req` = 0.
- Return to `IDLE`.
- A new grant can occur in the next `IDLE` cycle. The minimum gap between transactions is 2 cycles.

Requester behaviour:
- Requesters hold `req` and `addr` stable until their done.
- Deasserting `req` mid-transaction is ignored. The transaction completes and done still pulses.
- Address changes after the grant are ignored because the address is latched.

Busy outputs: `o_x_busy` = `i_x_req` OR (owner == x and state ≠ `IDLE`).

Reset, asynchronous while `Rst` is 0:
- State `IDLE`; `cnt`, `dstreak`, `owner` = 0.
- All outputs 0: `o_mem_*`, `fill_valid`, `done`, `o_fill_idx`, `o_fill_data`.
- Reset mid-burst abandons the transaction with no done pulse.

## Timing
- Grant latency: request seen in `IDLE` at edge n gives `o_mem_req` high from cycle n+1.
- Refill with zero-wait memory (ack every cycle): `LINE_WORDS` acks in cycles n+1…n+`LINE_WORDS`, done in cycle n+`LINE_WORDS`+1.
- Write-through: ack in n+1, done in n+2.
- Wait states: each word holds its address and `o_mem_req` until ack. No timeout.
- `fill_valid` and `done` are never asserted for the non-owner side. `o_ic_fill_valid` and `o_dc_fill_valid` are never high together.
- A request arriving during `BURST` or `FINISH` waits and is arbitrated at the next `IDLE`.

## Test plan
- **Reset:**
  - Stimulus: hold `Rst`=0 with requests active.
  - Required: all outputs 0.
  - Stimulus: release `Rst`, I request at 0x104.
  - Required: `o_mem_addr` = 0x100, 0x104, 0x108, 0x10C with idx 0–3, then `o_ic_done` one cycle after the 4th ack.
- **Write-through with wait states:**
  - Stimulus: D write to 0x2008, data 0xDEADBEEF; ack after 3 wait cycles.
  - Required: `o_mem_we`=1, addr/data stable for 4 cycles, `o_dc_done` the following cycle, no `fill_valid`.
- **Simultaneous requests:**
  - Stimulus: I and D refill requests raised in the same cycle.
  - Required: D serviced first, then I granted in the `IDLE` after D's done.
- **Starvation guard:**
  - Stimulus: I held continuously while D re-requests every `IDLE`.
  - Required: D, D, I, D, D, I grant order with `MAX_D_STREAK`=2.
- **Reset mid-burst:**
  - Stimulus: `Rst`=0 after the 2nd ack of a D refill.
  - Required: outputs 0 immediately, no `o_dc_done`. After release, a new I request starts at `cnt` 0.
- **Dropped request:**
  - Stimulus: I deasserts `req` after the 1st ack.
  - Required: all 4 words are still delivered and `o_ic_done` pulses. `o_ic_busy` stays high until `FINISH` ends.
